// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline control slice.
package pipe_pkg;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    localparam logic [9:0] NOP_WB   = 10'b0;
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard compare between the load in EX and the sources of ID.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       id_ex_mem_read,
    input  logic [4:0] id_ex_rt,
    output logic       load_use
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (id_ex_rt == id_rs);
    assign rt_match = id_uses_rt && (id_ex_rt == id_rt);

    // $zero never carries a real dependency.
    assign load_use = id_ex_mem_read && (id_ex_rt != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: memory wait FSM, branch flush, load-use stall,
// sticky dmem timeout flag and debug event counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rt,
    input  logic             ex_branch_taken,
    input  logic             ex_mem_mem_access,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                mem_err_q;
    logic [CNT_W-1:0]    stall_cnt_q;
    logic [CNT_W-1:0]    flush_cnt_q;

    logic load_use;
    logic timeout;
    logic mem_stall;

    hazard_detect u_hazard_detect (
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rt       (id_ex_rt),
        .load_use       (load_use)
    );

    assign timeout = (state_q == ST_MEM_WAIT) && !dmem_ack && (wcnt_q == WCNT_LAST);

    always_comb begin
        mem_stall = 1'b0;
        if (!rst) begin
            if (state_q == ST_RUN) begin
                mem_stall = ex_mem_mem_access && !dmem_ack;
            end else begin
                mem_stall = !dmem_ack && !timeout;
            end
        end
    end

    always_comb begin
        dmem_req      = 1'b0;
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b1;
        if (!rst) begin
            dmem_req = (state_q == ST_MEM_WAIT) || ex_mem_mem_access;
            if (!mem_stall) begin
                pc_en         = 1'b1;
                if_id_en      = 1'b1;
                id_ex_en      = 1'b1;
                ex_mem_en     = 1'b1;
                // A timed-out access still advances but its writeback is killed.
                mem_wb_bubble = timeout;
                if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        if (state_q == ST_RUN) begin
            wcnt_d = '0;
            if (ex_mem_mem_access && !dmem_ack) begin
                state_d = ST_MEM_WAIT;
            end
        end else begin
            if (dmem_ack || timeout) begin
                state_d = ST_RUN;
                wcnt_d  = '0;
            end else begin
                wcnt_d = wcnt_q + WCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wcnt_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (timeout) begin
                mem_err_q <= 1'b1;
            end
            if (!pc_en) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (if_id_flush) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with MEM_TIMEOUT=4.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rt;
    logic        ex_branch_taken;
    logic        ex_mem_mem_access;
    logic        dmem_ack;
    logic        dmem_req;
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mem_wb_bubble;
    logic        mem_err;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int total;
    int fails;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .id_rs             (id_rs),
        .id_rt             (id_rt),
        .id_uses_rt        (id_uses_rt),
        .id_ex_mem_read    (id_ex_mem_read),
        .id_ex_rt          (id_ex_rt),
        .ex_branch_taken   (ex_branch_taken),
        .ex_mem_mem_access (ex_mem_mem_access),
        .dmem_ack          (dmem_ack),
        .dmem_req          (dmem_req),
        .pc_en             (pc_en),
        .if_id_en          (if_id_en),
        .id_ex_en          (id_ex_en),
        .ex_mem_en         (ex_mem_en),
        .if_id_flush       (if_id_flush),
        .id_ex_flush       (id_ex_flush),
        .mem_wb_bubble     (mem_wb_bubble),
        .mem_err           (mem_err),
        .stall_cnt         (stall_cnt),
        .flush_cnt         (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs             = 5'd0;
        id_rt             = 5'd0;
        id_uses_rt        = 1'b0;
        id_ex_mem_read    = 1'b0;
        id_ex_rt          = 5'd0;
        ex_branch_taken   = 1'b0;
        ex_mem_mem_access = 1'b0;
        dmem_ack          = 1'b0;
    endtask

    initial begin
        total = 0;
        fails = 0;
        rst   = 1'b1;
        idle_inputs();
        tick();
        tick();

        // Reset state
        check("rst_pc_en", {31'b0, pc_en}, 32'd0);
        check("rst_if_id_en", {31'b0, if_id_en}, 32'd0);
        check("rst_id_ex_en", {31'b0, id_ex_en}, 32'd0);
        check("rst_ex_mem_en", {31'b0, ex_mem_en}, 32'd0);
        check("rst_bubble", {31'b0, mem_wb_bubble}, 32'd1);
        check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_flush_cnt", flush_cnt, 32'd0);
        check("rst_mem_err", {31'b0, mem_err}, 32'd0);

        rst = 1'b0;
        #1;
        check("idle_pc_en", {31'b0, pc_en}, 32'd1);
        check("idle_enables", {28'b0, if_id_en, id_ex_en, ex_mem_en, mem_wb_bubble}, 32'b1110);
        tick();
        check("idle_stall_cnt", stall_cnt, 32'd0);

        // Load-use on rs
        id_ex_mem_read = 1'b1;
        id_ex_rt       = 5'd5;
        id_rs          = 5'd5;
        #1;
        check("lu_pc_en", {31'b0, pc_en}, 32'd0);
        check("lu_if_id_en", {31'b0, if_id_en}, 32'd0);
        check("lu_id_ex_flush", {31'b0, id_ex_flush}, 32'd1);
        check("lu_id_ex_en", {31'b0, id_ex_en}, 32'd1);
        check("lu_if_id_flush", {31'b0, if_id_flush}, 32'd0);
        tick();
        idle_inputs();
        #1;
        check("lu_stall_cnt", stall_cnt, 32'd1);
        check("lu_released", {31'b0, pc_en}, 32'd1);

        // Load into $zero never stalls
        id_ex_mem_read = 1'b1;
        id_ex_rt       = 5'd0;
        id_rs          = 5'd0;
        #1;
        check("lu_zero_pc_en", {31'b0, pc_en}, 32'd1);
        check("lu_zero_flush", {31'b0, id_ex_flush}, 32'd0);
        tick();
        check("lu_zero_stall_cnt", stall_cnt, 32'd1);

        // rt match only counts when rt is a source
        id_ex_rt   = 5'd7;
        id_rt      = 5'd7;
        id_rs      = 5'd3;
        id_uses_rt = 1'b0;
        #1;
        check("lu_rt_unused", {31'b0, pc_en}, 32'd1);
        id_uses_rt = 1'b1;
        #1;
        check("lu_rt_used", {31'b0, pc_en}, 32'd0);
        tick();
        idle_inputs();
        #1;
        check("lu_rt_stall_cnt", stall_cnt, 32'd2);

        // Taken branch overrides a load-use match
        id_ex_mem_read  = 1'b1;
        id_ex_rt        = 5'd5;
        id_rs           = 5'd5;
        ex_branch_taken = 1'b1;
        #1;
        check("br_if_id_flush", {31'b0, if_id_flush}, 32'd1);
        check("br_id_ex_flush", {31'b0, id_ex_flush}, 32'd1);
        check("br_pc_en", {31'b0, pc_en}, 32'd1);
        tick();
        idle_inputs();
        #1;
        check("br_flush_cnt", flush_cnt, 32'd1);
        check("br_stall_cnt", stall_cnt, 32'd2);

        // Access acked 3 cycles after the request
        ex_mem_mem_access = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mw3_dmem_req", {31'b0, dmem_req}, 32'd1);
            check("mw3_frozen", {27'b0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_bubble},
                  32'b00001);
            tick();
        end
        dmem_ack = 1'b1;
        #1;
        check("mw3_ack_adv", {27'b0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_bubble},
              32'b11110);
        tick();
        idle_inputs();
        #1;
        check("mw3_stall_cnt", stall_cnt, 32'd5);
        check("mw3_req_off", {31'b0, dmem_req}, 32'd0);

        // Zero-wait access
        ex_mem_mem_access = 1'b1;
        dmem_ack          = 1'b1;
        #1;
        check("zw_req", {31'b0, dmem_req}, 32'd1);
        check("zw_no_freeze", {30'b0, pc_en, mem_wb_bubble}, 32'b10);
        tick();
        idle_inputs();
        #1;
        check("zw_still_run", {31'b0, pc_en}, 32'd1);
        check("zw_stall_cnt", stall_cnt, 32'd5);

        // Branch held during a memory stall, flushed on release
        ex_mem_mem_access = 1'b1;
        ex_branch_taken   = 1'b1;
        #1;
        check("brmw_held0", {29'b0, pc_en, if_id_flush, id_ex_flush}, 32'b000);
        tick();
        check("brmw_held1", {29'b0, pc_en, if_id_flush, id_ex_flush}, 32'b000);
        tick();
        dmem_ack = 1'b1;
        #1;
        check("brmw_release", {29'b0, pc_en, if_id_flush, id_ex_flush}, 32'b111);
        tick();
        idle_inputs();
        #1;
        check("brmw_flush_cnt", flush_cnt, 32'd2);
        check("brmw_stall_cnt", stall_cnt, 32'd7);

        // Timeout after 4 frozen cycles
        ex_mem_mem_access = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("to_frozen", {30'b0, pc_en, mem_wb_bubble}, 32'b01);
            tick();
        end
        #1;
        check("to_adv_bubble", {30'b0, pc_en, mem_wb_bubble}, 32'b11);
        check("to_err_pending", {31'b0, mem_err}, 32'd0);
        tick();
        idle_inputs();
        #1;
        check("to_mem_err", {31'b0, mem_err}, 32'd1);
        check("to_stall_cnt", stall_cnt, 32'd11);
        check("to_back_run", {30'b0, pc_en, dmem_req}, 32'b10);
        tick();
        tick();
        check("to_err_sticky", {31'b0, mem_err}, 32'd1);

        // Reset pulse in the middle of a wait
        ex_mem_mem_access = 1'b1;
        tick();
        tick();
        check("rmw_stalling", {31'b0, pc_en}, 32'd0);
        rst = 1'b1;
        #1;
        check("rmw_req_off", {31'b0, dmem_req}, 32'd0);
        check("rmw_mem_err", {31'b0, mem_err}, 32'd0);
        check("rmw_stall_cnt", stall_cnt, 32'd0);
        idle_inputs();
        tick();
        rst = 1'b0;
        #1;
        check("rmw_run", {30'b0, pc_en, dmem_req}, 32'b10);
        tick();
        check("rmw_no_err", {31'b0, mem_err}, 32'd0);
        check("rmw_no_stall", stall_cnt, 32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
